stack_queue_driver: RTL and testbench
=====================================

STACK_QUEUE_DRIVER -- requirements
Module: stack_queue_driver

Interface
REQ-001 SHALL have parameter SIZE, default 8, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, entries in the downstream buffer.
REQ-003 SHALL have parameter CHIP_SEL, default 2'b01, chip-enable value driven during buffer access.
REQ-004 SHALL have ports as follows; one clock; reset is synchronous and active-low:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when both high
cmd_op  in  1  0 = push, 1 = pop
cmd_data  in  SIZE  push data
cfg_mode  in  2  requested buffer mode
rsp_valid  out  1  response offered
rsp_ready  in  1  response consumed when both high
rsp_data  out  SIZE  pop data, or echo of push data
rsp_err  out  1  command rejected (push on full / pop on empty)
level  out  clog2(DEPTH+1)  shadow occupancy count
err_cnt  out  8  saturating rejected-command count
buf_write  out  1  write strobe to buffer
buf_read  out  1  read strobe to buffer
buf_chip_en  out  2  buffer chip enable
buf_mode  out  2  buffer mode
buf_dataIn  out  SIZE  data to buffer
buf_dataOut  in  SIZE  data from buffer, valid cycle after buf_read
buf_empty  in  1  buffer empty flag
buf_full  in  1  buffer full flag

Function
REQ-005 SHALL implement FSM with states IDLE, WRITE, READ, WAIT, RESP.
REQ-006 cmd_ready SHALL be 1 only in IDLE; at most one command in flight.
REQ-007 On accept in IDLE SHALL latch cmd_op, cmd_data, and sample buf_full/buf_empty in the same cycle.
REQ-008 IDLE: push with buf_full=0 -> WRITE; pop with buf_empty=0 -> READ; push with buf_full=1 or pop with buf_empty=1 -> RESP with rsp_err=1, rsp_data=0, no strobe.
REQ-009 WRITE: buf_write=1, buf_dataIn=latched data, buf_chip_en=CHIP_SEL for exactly one cycle; level+1; next RESP, rsp_err=0, rsp_data=latched data.
REQ-010 READ: buf_read=1, buf_chip_en=CHIP_SEL for exactly one cycle; level-1; next WAIT.
REQ-011 WAIT: capture buf_dataOut into rsp_data; next RESP, rsp_err=0.
REQ-012 RESP: rsp_valid=1; rsp_data/rsp_err stable until rsp_ready=1, then IDLE next cycle.
REQ-013 Outside WRITE/READ: buf_write=0, buf_read=0, buf_chip_en=2'b00; buf_write and buf_read never both 1.
REQ-014 Latency cmd accept -> rsp_valid: push 2 cycles, pop 3 cycles, rejected 1 cycle.
REQ-015 buf_mode SHALL load cfg_mode only in IDLE when buf_empty=1 and level=0; otherwise hold.
REQ-016 level SHALL saturate at 0 and DEPTH; never wraps.
REQ-017 err_cnt SHALL increment on each rejected accept, saturating at 255.
REQ-018 Back-to-back: a new command SHALL be accepted in the cycle IDLE is re-entered; no cycle skipped beyond FSM latency.

Reset
REQ-019 reset=0 at rising edge SHALL force IDLE; cmd_ready=0 during reset, rsp_valid=0, rsp_data=0, rsp_err=0, level=0, err_cnt=0, buf_write=0, buf_read=0, buf_chip_en=0, buf_mode=0, buf_dataIn=0.
REQ-020 Reset mid-operation SHALL abandon the in-flight command with no response; strobes deasserted from the next edge.

Verification
REQ-021 Push 8'hA5 on empty buffer -> buf_write pulse 1 cycle with buf_dataIn=A5, rsp_valid 2 cycles after accept, rsp_data=A5, rsp_err=0, level=1.
REQ-022 Pop with buf_dataOut=8'h3C after read -> buf_read pulse 1 cycle, rsp_data=3C 3 cycles after accept, level decremented.
REQ-023 Pop with buf_empty=1 -> no strobe, rsp_err=1 after 1 cycle, err_cnt+1; push with buf_full=1 likewise.
REQ-024 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_data stable, cmd_ready=0 throughout.
REQ-025 cfg_mode 00->01 with level=2 -> buf_mode unchanged until two pops drain level to 0 and buf_empty=1, then buf_mode=01.
REQ-026 reset=0 asserted in READ -> next cycle buf_read=0, rsp_valid=0, level=0, state IDLE.

Source files
------------

// File: rtl/stack_queue_driver.sv
// stack_queue_driver: accepts push/pop commands one at a time, drives a
// single-cycle strobe into a downstream buffer, and returns one response per
// command. Keeps a shadow occupancy count and a saturating reject counter.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and the offered payload stays stable
// while valid is high and ready is low.
module stack_queue_driver #(
    parameter int          SIZE     = 8,
    parameter int          DEPTH    = 8,
    parameter logic [1:0]  CHIP_SEL = 2'b01,
    localparam int         LW       = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_op,
    input  logic [SIZE-1:0] cmd_data,
    input  logic [1:0]      cfg_mode,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [SIZE-1:0] rsp_data,
    output logic            rsp_err,
    output logic [LW-1:0]   level,
    output logic [7:0]      err_cnt,
    output logic            buf_write,
    output logic            buf_read,
    output logic [1:0]      buf_chip_en,
    output logic [1:0]      buf_mode,
    output logic [SIZE-1:0] buf_dataIn,
    input  logic [SIZE-1:0] buf_dataOut,
    input  logic            buf_empty,
    input  logic            buf_full,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [SIZE-1:0] data_q;
    logic            accept;
    logic            reject;

    // A command is taken only in IDLE and only while out of reset.
    assign cmd_ready = reset && (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    // Flags are judged in the accept cycle itself, not later.
    assign reject    = accept && ((!cmd_op && buf_full) || (cmd_op && buf_empty));
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection and buffer strobes decoded from the current state.
    always_comb begin
        state_next  = state;
        buf_write   = 1'b0;
        buf_read    = 1'b0;
        buf_chip_en = 2'b00;
        buf_dataIn  = '0;
        rsp_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (reject) begin
                        state_next = RESP;
                    end else if (cmd_op) begin
                        state_next = READ;
                    end else begin
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                buf_write   = 1'b1;
                buf_chip_en = CHIP_SEL;
                buf_dataIn  = data_q;
                state_next  = RESP;
            end
            READ: begin
                buf_read    = 1'b1;
                buf_chip_en = CHIP_SEL;
                state_next  = WAIT;
            end
            WAIT: begin
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command latch, response payload, occupancy and error bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            level    <= '0;
            err_cnt  <= 8'd0;
            buf_mode <= 2'b00;
        end else begin
            if (accept) begin
                data_q <= cmd_data;
            end
            if (reject) begin
                rsp_err  <= 1'b1;
                rsp_data <= '0;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
            case (state)
                WRITE: begin
                    rsp_data <= data_q;
                    rsp_err  <= 1'b0;
                    if (level != LW'(DEPTH)) begin
                        level <= level + 1'b1;
                    end
                end
                READ: begin
                    if (level != '0) begin
                        level <= level - 1'b1;
                    end
                end
                WAIT: begin
                    // Buffer data is valid the cycle after the read strobe.
                    rsp_data <= buf_dataOut;
                    rsp_err  <= 1'b0;
                end
                default: begin
                end
            endcase
            // Mode may only change while the buffer is known to be drained.
            if ((state == IDLE) && buf_empty && (level == '0)) begin
                buf_mode <= cfg_mode;
            end
        end
    end

endmodule

// File: tb/tb_stack_queue_driver.sv
// Directed bench for stack_queue_driver: a driver task issues commands and
// pushes the expected response word; a monitor pops and compares on every
// response handshake. Inputs change 1 time unit after the rising edge and all
// outputs are sampled on the falling edge.
module tb_stack_queue_driver;

  localparam int         SIZE     = 8;
  localparam int         DEPTH    = 8;
  localparam logic [1:0] CHIP_SEL = 2'b01;
  localparam int         LW       = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic            cmd_op = 1'b0;
  logic [SIZE-1:0] cmd_data = '0;
  logic [1:0]      cfg_mode = 2'b00;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [SIZE-1:0] rsp_data;
  logic            rsp_err;
  logic [LW-1:0]   level;
  logic [7:0]      err_cnt;
  logic            buf_write;
  logic            buf_read;
  logic [1:0]      buf_chip_en;
  logic [1:0]      buf_mode;
  logic [SIZE-1:0] buf_dataIn;
  logic [SIZE-1:0] buf_dataOut = 8'hEE;
  logic            buf_empty = 1'b1;
  logic            buf_full = 1'b0;
  logic [2:0]      dbg_state;

  stack_queue_driver #(.SIZE(SIZE), .DEPTH(DEPTH), .CHIP_SEL(CHIP_SEL)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cfg_mode(cfg_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .level(level), .err_cnt(err_cnt),
    .buf_write(buf_write), .buf_read(buf_read), .buf_chip_en(buf_chip_en),
    .buf_mode(buf_mode), .buf_dataIn(buf_dataIn), .buf_dataOut(buf_dataOut),
    .buf_empty(buf_empty), .buf_full(buf_full),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [SIZE:0] exp_q[$];   // {rsp_err, rsp_data}
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response handshake must match the oldest expectation.
  initial begin
    logic [SIZE:0] e;
    forever begin
      @(negedge clk);
      if (reset && rsp_valid && rsp_ready) begin
        check("rsp_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rsp_word", {rsp_err, rsp_data}, e);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_cmd(input logic op, input logic [7:0] data, input logic full,
                         input logic empty, input logic [7:0] dout, input bit stall,
                         input int exp_lat, input logic exp_err, input logic [7:0] exp_data,
                         input int exp_wr, input int exp_rd);
    int waits;
    int cycles;
    int wr_n;
    int rd_n;
    logic rd_seen;
    logic done;
    logic [SIZE-1:0] held;
    @(posedge clk); #1;
    cmd_op = op; cmd_data = data; buf_full = full; buf_empty = empty;
    rsp_ready = !stall; cmd_valid = 1'b1;
    exp_q.push_back({exp_err, exp_data});
    waits = 0;
    @(negedge clk);
    while (!cmd_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    check("accept_wait", waits, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_data = 8'h00;
    cycles = 0; wr_n = 0; rd_n = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      cycles++;
      rd_seen = buf_read;
      check("strobe_overlap", 32'(buf_write & buf_read), 0);
      if (buf_write) begin
        wr_n++;
        check("buf_dataIn", buf_dataIn, data);
        check("wr_chip_en", buf_chip_en, CHIP_SEL);
      end
      if (buf_read) begin
        rd_n++;
        check("rd_chip_en", buf_chip_en, CHIP_SEL);
      end
      if (!buf_write && !buf_read) check("idle_chip_en", buf_chip_en, 0);
      if (rsp_valid || cycles >= 20) begin
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        buf_dataOut = rd_seen ? dout : 8'hEE;
      end
    end
    check("rsp_latency", cycles, exp_lat);
    check("write_pulses", wr_n, exp_wr);
    check("read_pulses", rd_n, exp_rd);
    if (stall) begin
      held = rsp_data;
      check("stall_data", held, exp_data);
      repeat (5) begin
        @(negedge clk);
        check("stall_valid", rsp_valid, 1);
        check("stall_hold", rsp_data, held);
        check("stall_cmd_ready", cmd_ready, 0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_level", level, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_buf_write", buf_write, 0);
    check("rst_buf_read", buf_read, 0);
    check("rst_chip_en", buf_chip_en, 0);
    check("rst_buf_mode", buf_mode, 0);
    check("rst_buf_dataIn", buf_dataIn, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Push A5 into an empty buffer, then 5A.
    run_cmd(1'b0, 8'hA5, 1'b0, 1'b1, 8'h00, 0, 2, 1'b0, 8'hA5, 1, 0);
    check("level_push1", level, 1);
    run_cmd(1'b0, 8'h5A, 1'b0, 1'b0, 8'h00, 0, 2, 1'b0, 8'h5A, 1, 0);
    check("level_push2", level, 2);

    // Mode request while occupied must wait for a full drain.
    cfg_mode = 2'b01;
    run_cmd(1'b1, 8'h00, 1'b0, 1'b0, 8'h3C, 0, 3, 1'b0, 8'h3C, 0, 1);
    check("level_pop1", level, 1);
    check("mode_hold1", buf_mode, 2'b00);
    run_cmd(1'b1, 8'h00, 1'b0, 1'b0, 8'h77, 0, 3, 1'b0, 8'h77, 0, 1);
    check("level_pop2", level, 0);
    check("mode_hold2", buf_mode, 2'b00);
    @(posedge clk); #1;
    buf_empty = 1'b1;
    @(negedge clk);
    check("mode_hold3", buf_mode, 2'b00);
    @(negedge clk);
    check("mode_load", buf_mode, 2'b01);

    // Rejects: pop on empty, push on full.
    run_cmd(1'b1, 8'h00, 1'b0, 1'b1, 8'h55, 0, 1, 1'b1, 8'h00, 0, 0);
    check("err_cnt1", err_cnt, 1);
    run_cmd(1'b0, 8'hB7, 1'b1, 1'b0, 8'h00, 0, 1, 1'b1, 8'h00, 0, 0);
    check("err_cnt2", err_cnt, 2);
    check("level_after_rej", level, 0);

    // Pop at shadow level 0 with the buffer claiming data: level stays 0.
    run_cmd(1'b1, 8'h00, 1'b0, 1'b0, 8'h99, 0, 3, 1'b0, 8'h99, 0, 1);
    check("level_floor", level, 0);

    // Response held off for 5 cycles.
    run_cmd(1'b0, 8'hC3, 1'b0, 1'b0, 8'h00, 1, 2, 1'b0, 8'hC3, 1, 0);
    check("level_stall", level, 1);

    // Back-to-back pushes up to and past DEPTH.
    for (int i = 0; i < 9; i++) begin
      run_cmd(1'b0, 8'(8'h10 + i), 1'b0, 1'b0, 8'h00, 0, 2, 1'b0, 8'(8'h10 + i), 1, 0);
      check("level_ceiling", level, (2 + i > DEPTH) ? DEPTH : 2 + i);
    end

    // Reject counter saturates at 255.
    for (int i = 0; i < 260; i++) begin
      run_cmd(1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 0, 1, 1'b1, 8'h00, 0, 0);
    end
    check("err_cnt_sat", err_cnt, 255);
    check("level_before_rst", level, DEPTH);

    // Reset while in READ abandons the pop.
    @(posedge clk); #1;
    cmd_op = 1'b1; buf_empty = 1'b0; buf_full = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    check("mid_accept", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("mid_in_read", buf_read, 1);
    @(negedge clk);
    check("mid_rst_read", buf_read, 0);
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_state", dbg_state, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    check("mid_rst_mode", buf_mode, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("no_stray_rsp", rsp_valid, 0);

    // Recovery after reset.
    run_cmd(1'b0, 8'h42, 1'b0, 1'b1, 8'h00, 0, 2, 1'b0, 8'h42, 1, 0);
    check("level_recover", level, 1);

    repeat (2) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
